// File: rtl/pulse_width_meter.sv
// Measures high/low phase durations from edge-detector strobes and presents each
// qualifying measurement on a single-entry valid/ready output register.
module pulse_width_meter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned MIN_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rise,
    input  logic             fall,
    input  logic             clr,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_len,
    output logic             m_level,
    output logic             m_sat,
    output logic             ovr,
    output logic             perr
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] MinLen = CNT_W'(MIN_W);

    typedef enum logic [0:0] {StArming, StMeas} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cur_lvl_q, cur_lvl_d;
    logic             sat_q, sat_d;
    logic             m_valid_q, m_valid_d;
    logic [CNT_W-1:0] m_len_q, m_len_d;
    logic             m_level_q, m_level_d;
    logic             m_sat_q, m_sat_d;
    logic             ovr_q, ovr_d;
    logic             perr_q, perr_d;

    logic one_edge;
    logic both_edges;
    logic report;

    // Simultaneous rise and fall is a protocol error, never a real edge.
    assign one_edge   = rise ^ fall;
    assign both_edges = rise & fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StArming;
            cnt_q     <= '0;
            cur_lvl_q <= 1'b0;
            sat_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_len_q   <= '0;
            m_level_q <= 1'b0;
            m_sat_q   <= 1'b0;
            ovr_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_lvl_q <= cur_lvl_d;
            sat_q     <= sat_d;
            m_valid_q <= m_valid_d;
            m_len_q   <= m_len_d;
            m_level_q <= m_level_d;
            m_sat_q   <= m_sat_d;
            ovr_q     <= ovr_d;
            perr_q    <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = StArming;
        end else if (state_q == StArming && one_edge) begin
            state_d = StMeas;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        cur_lvl_d = cur_lvl_q;
        sat_d     = sat_q;
        m_valid_d = m_valid_q;
        m_len_d   = m_len_q;
        m_level_d = m_level_q;
        m_sat_d   = m_sat_q;
        ovr_d     = ovr_q;
        perr_d    = perr_q;
        report    = 1'b0;

        if (clr) begin
            cnt_d     = '0;
            cur_lvl_d = 1'b0;
            sat_d     = 1'b0;
            m_valid_d = 1'b0;
            m_len_d   = '0;
            m_level_d = 1'b0;
            m_sat_d   = 1'b0;
            ovr_d     = 1'b0;
            perr_d    = 1'b0;
        end else begin
            if (both_edges) begin
                perr_d = 1'b1;
            end

            unique case (state_q)
                StArming: begin
                    if (one_edge) begin
                        cnt_d     = CntOne;
                        cur_lvl_d = rise;
                        sat_d     = 1'b0;
                    end
                end
                StMeas: begin
                    if (one_edge) begin
                        cnt_d = CntOne;
                        sat_d = 1'b0;
                        if (rise != cur_lvl_q) begin
                            cur_lvl_d = rise;
                            report    = (cnt_q >= MinLen);
                        end else begin
                            perr_d = 1'b1;
                        end
                    end else if (cnt_q == CntMax) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: ;
            endcase

            // Single-entry output: a push is accepted when empty or popping this cycle.
            if (report) begin
                if (!m_valid_q || m_ready) begin
                    m_valid_d = 1'b1;
                    m_len_d   = cnt_q;
                    m_level_d = cur_lvl_q;
                    m_sat_d   = sat_q;
                end else begin
                    ovr_d = 1'b1;
                end
            end else if (m_valid_q && m_ready) begin
                m_valid_d = 1'b0;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_len   = m_len_q;
    assign m_level = m_level_q;
    assign m_sat   = m_sat_q;
    assign ovr     = ovr_q;
    assign perr    = perr_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: two instances (16-bit/MIN 2 and 4-bit/MIN 1).
module tb_pulse_width_meter;

    typedef struct packed {
        logic [15:0] len;
        logic        lvl;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        rise_a, fall_a, clr_a, m_ready_a;
    logic        m_valid_a, m_level_a, m_sat_a, ovr_a, perr_a;
    logic [15:0] m_len_a;

    logic        rise_b, fall_b, clr_b, m_ready_b;
    logic        m_valid_b, m_level_b, m_sat_b, ovr_b, perr_b;
    logic [3:0]  m_len_b;

    exp_t q_a[$];
    exp_t q_b[$];

    int n_checks = 0;
    int n_errors = 0;

    pulse_width_meter #(.CNT_W(16), .MIN_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .rise(rise_a), .fall(fall_a), .clr(clr_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .m_len(m_len_a),
        .m_level(m_level_a), .m_sat(m_sat_a), .ovr(ovr_a), .perr(perr_a)
    );

    pulse_width_meter #(.CNT_W(4), .MIN_W(1)) u_b (
        .clk(clk), .rst_n(rst_n), .rise(rise_b), .fall(fall_b), .clr(clr_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_len(m_len_b),
        .m_level(m_level_b), .m_sat(m_sat_b), .ovr(ovr_b), .perr(perr_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one edge strobe, then idle so the next edge lands n cycles later.
    task automatic ev_a(input logic r, input logic f, input int n, input bit push,
                        input int len, input logic lvl, input logic sat);
        exp_t e;
        if (push) begin
            e.len = 16'(len);
            e.lvl = lvl;
            e.sat = sat;
            q_a.push_back(e);
        end
        rise_a = r;
        fall_a = f;
        wait_cyc(1);
        rise_a = 1'b0;
        fall_a = 1'b0;
        wait_cyc(n - 1);
    endtask

    task automatic ev_b(input logic r, input logic f, input int n, input bit push,
                        input int len, input logic lvl, input logic sat);
        exp_t e;
        if (push) begin
            e.len = 16'(len);
            e.lvl = lvl;
            e.sat = sat;
            q_b.push_back(e);
        end
        rise_b = r;
        fall_b = f;
        wait_cyc(1);
        rise_b = 1'b0;
        fall_b = 1'b0;
        wait_cyc(n - 1);
    endtask

    task automatic do_clr_a();
        clr_a = 1'b1;
        wait_cyc(1);
        clr_a = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        rise_a    = 1'b0; fall_a = 1'b0; clr_a = 1'b0; m_ready_a = 1'b1;
        rise_b    = 1'b0; fall_b = 1'b0; clr_b = 1'b0; m_ready_b = 1'b1;

        // Monitor: pops the scoreboard on every accepted transfer.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst_n && m_valid_a && m_ready_a) begin
                    if (q_a.size() == 0) begin
                        chk("a_unexpected_report", 32'({m_len_a, m_level_a, m_sat_a}), 32'hffffffff);
                    end else begin
                        e = q_a.pop_front();
                        chk("a_report", 32'({m_len_a, m_level_a, m_sat_a}), 32'(e));
                    end
                end
                if (rst_n && m_valid_b && m_ready_b) begin
                    if (q_b.size() == 0) begin
                        chk("b_unexpected_report", 32'({12'd0, m_len_b, m_level_b, m_sat_b}),
                            32'hffffffff);
                    end else begin
                        e = q_b.pop_front();
                        chk("b_report", 32'({12'd0, m_len_b, m_level_b, m_sat_b}), 32'(e));
                    end
                end
            end
        join_none

        wait_cyc(3);
        chk("rst_m_valid", 32'(m_valid_a), 32'd0);
        chk("rst_m_len",   32'(m_len_a),   32'd0);
        chk("rst_m_level", 32'(m_level_a), 32'd0);
        chk("rst_m_sat",   32'(m_sat_a),   32'd0);
        chk("rst_ovr",     32'(ovr_a),     32'd0);
        chk("rst_perr",    32'(perr_a),    32'd0);
        chk("rst_b_valid", 32'(m_valid_b), 32'd0);
        rst_n = 1'b1;
        wait_cyc(5);

        // Saturation on 4-bit counter, then back-to-back 1-cycle phases.
        ev_b(1'b1, 1'b0, 40, 1'b0, 0, 1'b0, 1'b0);
        ev_b(1'b0, 1'b1, 3,  1'b1, 15, 1'b1, 1'b1);
        ev_b(1'b1, 1'b0, 1,  1'b1, 3, 1'b0, 1'b0);
        ev_b(1'b0, 1'b1, 1,  1'b1, 1, 1'b1, 1'b0);
        ev_b(1'b1, 1'b0, 1,  1'b1, 1, 1'b0, 1'b0);
        ev_b(1'b0, 1'b1, 1,  1'b1, 1, 1'b1, 1'b0);
        ev_b(1'b1, 1'b0, 5,  1'b1, 1, 1'b0, 1'b0);
        chk("b_ovr_b2b",   32'(ovr_b),     32'd0);
        chk("b_perr_b2b",  32'(perr_b),    32'd0);
        chk("b_valid_end", 32'(m_valid_b), 32'd0);

        // Basic high/low measurement; first phase before arming is not reported.
        ev_a(1'b1, 1'b0, 5, 1'b0, 0, 1'b0, 1'b0);
        ev_a(1'b0, 1'b1, 7, 1'b1, 5, 1'b1, 1'b0);
        ev_a(1'b1, 1'b0, 6, 1'b1, 7, 1'b0, 1'b0);
        chk("basic_ovr",  32'(ovr_a),  32'd0);
        chk("basic_perr", 32'(perr_a), 32'd0);

        // clr wins over a phase-ending fall in the same cycle.
        clr_a  = 1'b1;
        fall_a = 1'b1;
        wait_cyc(1);
        clr_a  = 1'b0;
        fall_a = 1'b0;

        // Glitch rejection: 1-cycle high phase dropped, following low phase kept.
        ev_a(1'b1, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0);
        ev_a(1'b0, 1'b1, 9, 1'b0, 0, 1'b0, 1'b0);
        ev_a(1'b1, 1'b0, 6, 1'b1, 9, 1'b0, 1'b0);

        // Backpressure: first report held, later ones dropped with ovr.
        m_ready_a = 1'b0;
        ev_a(1'b0, 1'b1, 4, 1'b1, 6, 1'b1, 1'b0);
        ev_a(1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0);
        ev_a(1'b0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        wait_cyc(1);
        chk("hold_valid", 32'(m_valid_a), 32'd1);
        chk("hold_len",   32'(m_len_a),   32'd6);
        chk("hold_level", 32'(m_level_a), 32'd1);
        chk("hold_ovr",   32'(ovr_a),     32'd1);
        m_ready_a = 1'b1;
        wait_cyc(3);
        chk("drain_valid", 32'(m_valid_a), 32'd0);

        // Protocol errors and clear.
        do_clr_a();
        chk("clr_ovr",   32'(ovr_a),     32'd0);
        chk("clr_perr",  32'(perr_a),    32'd0);
        chk("clr_valid", 32'(m_valid_a), 32'd0);
        ev_a(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
        chk("both_perr", 32'(perr_a), 32'd1);
        do_clr_a();
        ev_a(1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0);
        ev_a(1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0);
        chk("dup_perr", 32'(perr_a), 32'd1);
        ev_a(1'b0, 1'b1, 4, 1'b1, 3, 1'b1, 1'b0);
        do_clr_a();
        chk("clr2_perr", 32'(perr_a), 32'd0);
        ev_a(1'b0, 1'b1, 4, 1'b0, 0, 1'b0, 1'b0);
        ev_a(1'b1, 1'b0, 5, 1'b1, 4, 1'b0, 1'b0);

        // Reset mid-phase with a held report and sticky perr.
        m_ready_a = 1'b0;
        ev_a(1'b0, 1'b1, 3, 1'b1, 5, 1'b1, 1'b0);
        ev_a(1'b1, 1'b1, 2, 1'b0, 0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(m_valid_a), 32'd1);
        chk("pre_rst_len",   32'(m_len_a),   32'd5);
        chk("pre_rst_perr",  32'(perr_a),    32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(m_valid_a), 32'd0);
        chk("arst_len",   32'(m_len_a),   32'd0);
        chk("arst_level", 32'(m_level_a), 32'd0);
        chk("arst_sat",   32'(m_sat_a),   32'd0);
        chk("arst_ovr",   32'(ovr_a),     32'd0);
        chk("arst_perr",  32'(perr_a),    32'd0);
        if (q_a.size() != 0) begin
            void'(q_a.pop_front());
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        m_ready_a = 1'b1;
        wait_cyc(4);
        chk("post_rst_valid", 32'(m_valid_a), 32'd0);

        chk("a_queue_empty", 32'(q_a.size()), 32'd0);
        chk("b_queue_empty", 32'(q_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
